// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: word width, store-buffer entry layout and a
// byte-address to word-number helper.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

  // Word number of a byte address (byte offset dropped, zero-extended).
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/sb_match_prio.sv
// Load-address lookup over the store buffer: builds the per-entry word-index
// hit vector and picks the youngest hitting slot, walking from the head
// (oldest) towards the tail so the last hit seen is the youngest one.
module sb_match_prio #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 30,
  parameter int PTR_W = 2
) (
  input  logic [IDX_W-1:0]            i_ld_idx,
  input  logic [DEPTH-1:0][IDX_W-1:0] i_entry_idx,
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [PTR_W-1:0]            i_head,
  output logic [DEPTH-1:0]            o_hit_vec,
  output logic [PTR_W-1:0]            o_sel
);

  logic [PTR_W-1:0] w_slot;

  // Per-entry hit: only live entries whose word index equals the load's.
  always_comb begin
    o_hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit_vec[i] = i_valid[i] && (i_entry_idx[i] == i_ld_idx);
    end
  end

  // Age-ordered scan from head; a later (younger) hit overrides an older one.
  always_comb begin
    w_slot = '0;
    o_sel  = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = i_head + PTR_W'(k);
      if (o_hit_vec[w_slot]) begin
        o_sel = w_slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and the word-addressed data memory.
// Stores retire into a circular FIFO in one cycle and drain on cycles without
// a load; loads always win the memory port.
// Build option STORE_BUF_FWD_EN: when defined, loads are forwarded from the
// youngest matching buffered store; when undefined, a load that matches a
// buffered store stalls until the matching entries have drained.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_st_valid,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic [DATA_W-1:0] o_ld_data,
  output logic              o_stall,
  output logic              o_empty,
  output logic              o_mem_MemRead,
  output logic              o_mem_MemWrite,
  output logic [ADDR_W-1:0] o_mem_Address,
  output logic [DATA_W-1:0] o_mem_Write_data,
  input  logic [DATA_W-1:0] i_mem_Read_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W - 2;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [DEPTH-1:0][IDX_W-1:0] w_entry_idx;
  logic [DEPTH-1:0]            w_hit_vec;
  logic [PTR_W-1:0]            w_sel;
  logic                        w_any_hit;
  logic                        w_full;
  logic                        w_ld_go;
  logic                        w_stall_raw;
  logic                        w_drain;
  logic                        w_enq;
  logic [DATA_W-1:0]           w_ld_result;

  // Word indices of every slot, fed to the lookup.
  always_comb begin
    w_entry_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_idx[i] = r_addr[i][ADDR_W-1:2];
    end
  end

  sb_match_prio #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .PTR_W (PTR_W)
  ) u_match (
    .i_ld_idx    (i_ld_addr[ADDR_W-1:2]),
    .i_entry_idx (w_entry_idx),
    .i_valid     (r_valid),
    .i_head      (r_head),
    .o_hit_vec   (w_hit_vec),
    .o_sel       (w_sel)
  );

  assign w_any_hit = |w_hit_vec;
  assign w_full    = (r_count == CNT_W'(DEPTH));

`ifdef STORE_BUF_FWD_EN
  // Loads always proceed; a hit is served from the youngest matching entry.
  assign w_ld_go     = i_ld_valid;
  assign w_stall_raw = i_st_valid && w_full && i_ld_valid;
  assign w_ld_result = w_any_hit ? r_data[w_sel] : i_mem_Read_data;
`else
  // A matching load is held off so the port drains the older stores first.
  logic [PTR_W-1:0] w_unused_sel;
  assign w_unused_sel = w_sel;
  assign w_ld_go      = i_ld_valid && !w_any_hit;
  assign w_stall_raw  = i_ld_valid && (w_any_hit || (i_st_valid && w_full));
  assign w_ld_result  = i_mem_Read_data;
`endif

  assign o_stall   = !i_rst && w_stall_raw;
  assign o_empty   = i_rst || (r_count == '0);
  assign o_ld_data = (i_rst || !i_ld_valid) ? '0 : w_ld_result;
  assign w_drain   = !i_rst && !w_ld_go && (r_count != '0);
  assign w_enq     = !i_rst && i_st_valid && !o_stall;

  // Memory-port arbitration: load first, otherwise drain the head entry.
  always_comb begin
    o_mem_MemRead    = 1'b0;
    o_mem_MemWrite   = 1'b0;
    o_mem_Address    = '0;
    o_mem_Write_data = '0;
    if (!i_rst) begin
      if (w_ld_go) begin
        o_mem_MemRead = 1'b1;
        o_mem_Address = i_ld_addr;
      end else if (r_count != '0) begin
        o_mem_MemWrite   = 1'b1;
        o_mem_Address    = r_addr[r_head];
        o_mem_Write_data = r_data[r_head];
      end
    end
  end

  // FIFO control: drain clears head before enqueue sets tail, so a full
  // buffer that drains and enqueues in one cycle keeps the shared slot valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
    end
  end

  // Entry payload; valid bits gate every use, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= i_st_addr;
      r_data[r_tail] <= i_st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a drain scoreboard and a small data
// memory model. Expectations for loads that match buffered stores follow
// STORE_BUF_FWD_EN.
module tb_store_buffer;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stValid = 1'b0;
  logic [31:0] stAddr = '0;
  logic [31:0] stData = '0;
  logic        ldValid = 1'b0;
  logic [31:0] ldAddr = '0;
  logic [31:0] ldData;
  logic        stall;
  logic        empty;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  int total = 0;
  int bad   = 0;
  sb_entry_t expQ[$];

  logic [31:0] mem [0:63];
  bit   [63:0] memWritten;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_st_valid       (stValid),
    .i_st_addr        (stAddr),
    .i_st_data        (stData),
    .i_ld_valid       (ldValid),
    .i_ld_addr        (ldAddr),
    .o_ld_data        (ldData),
    .o_stall          (stall),
    .o_empty          (empty),
    .o_mem_MemRead    (memRead),
    .o_mem_MemWrite   (memWrite),
    .o_mem_Address    (memAddress),
    .o_mem_Write_data (memWriteData),
    .i_mem_Read_data  (memReadData)
  );

  // Unwritten words read back as a recognisable pattern of their index.
  function automatic logic [31:0] memPeek(input logic [5:0] idx);
    return memWritten[idx] ? mem[idx] : (32'hA000_0000 | {26'd0, idx});
  endfunction

  // Combinational-read data memory.
  always_comb begin
    memReadData = memPeek(memAddress[7:2]);
  end

  // Memory write port.
  always @(posedge clk) begin
    if (memWrite) begin
      mem[memAddress[7:2]]        <= memWriteData;
      memWritten[memAddress[7:2]] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic lv, input logic [31:0] la);
    rst     = r;
    stValid = sv;
    stAddr  = sa;
    stData  = sd;
    ldValid = lv;
    ldAddr  = la;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] a, input logic [31:0] d);
    sb_entry_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic drainAll(input string tag);
    int n;
    n = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    while (empty !== 1'b1 && n < 20) begin
      stepClock();
      n++;
    end
    checkOutput({tag, "_empty"}, {31'd0, empty}, 32'd1);
    checkOutput({tag, "_queue"}, expQ.size(), 32'd0);
  endtask

  // Scoreboard: every memory write must be the oldest outstanding store.
  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      checkOutput("drain_expected", {31'd0, (expQ.size() != 0)}, 32'd1);
      if (expQ.size() != 0) begin
        sb_entry_t e;
        e = expQ.pop_front();
        checkOutput("drain_addr", memAddress, e.addr);
        checkOutput("drain_data", memWriteData, e.data);
      end
    end
  end

  // Bound on total run time.
  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with active requests: every output must stay quiet.
    applyStimulus(1, 1, 32'h10, 32'h1, 1, 32'h10);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_memwrite", {31'd0, memWrite}, 32'd0);
    checkOutput("rst_memread", {31'd0, memRead}, 32'd0);
    checkOutput("rst_addr", memAddress, 32'd0);
    checkOutput("rst_wdata", memWriteData, 32'd0);
    checkOutput("rst_lddata", ldData, 32'd0);
    stepClock();
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_empty", {31'd0, empty}, 32'd1);
    checkOutput("idle_memread", {31'd0, memRead}, 32'd0);
    checkOutput("idle_memwrite", {31'd0, memWrite}, 32'd0);
    checkOutput("idle_lddata", ldData, 32'd0);

    // Single store drains on the following cycle.
    applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
    checkOutput("t1_stall", {31'd0, stall}, 32'd0);
    checkOutput("t1_memwrite0", {31'd0, memWrite}, 32'd0);
    pushExp(32'h10, 32'hDEADBEEF);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_memwrite1", {31'd0, memWrite}, 32'd1);
    checkOutput("t1_addr", memAddress, 32'h10);
    checkOutput("t1_wdata", memWriteData, 32'hDEADBEEF);
    checkOutput("t1_busy", {31'd0, empty}, 32'd0);
    stepClock();
    checkOutput("t1_empty", {31'd0, empty}, 32'd1);
    checkOutput("t1_mem", memPeek(6'd4), 32'hDEADBEEF);

    // Two stores to the same word held in the buffer, then a load of it.
    applyStimulus(0, 1, 32'h20, 32'h11, 1, 32'h80);
    checkOutput("t2_stall_a", {31'd0, stall}, 32'd0);
    checkOutput("t2_memread", {31'd0, memRead}, 32'd1);
    checkOutput("t2_ld_mem", ldData, 32'hA000_0020);
    pushExp(32'h20, 32'h11);
    stepClock();
    applyStimulus(0, 1, 32'h20, 32'h22, 1, 32'h80);
    checkOutput("t2_stall_b", {31'd0, stall}, 32'd0);
    checkOutput("t2_nowrite", {31'd0, memWrite}, 32'd0);
    pushExp(32'h20, 32'h22);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 32'h20);
`ifdef STORE_BUF_FWD_EN
    checkOutput("t2_fwd_stall", {31'd0, stall}, 32'd0);
    checkOutput("t2_fwd_nowrite", {31'd0, memWrite}, 32'd0);
    checkOutput("t2_fwd_memread", {31'd0, memRead}, 32'd1);
    checkOutput("t2_fwd_data", ldData, 32'h22);
    stepClock();
`else
    checkOutput("t2_hold_stall1", {31'd0, stall}, 32'd1);
    checkOutput("t2_hold_noread", {31'd0, memRead}, 32'd0);
    checkOutput("t2_hold_write1", {31'd0, memWrite}, 32'd1);
    checkOutput("t2_hold_addr", memAddress, 32'h20);
    stepClock();
    checkOutput("t2_hold_stall2", {31'd0, stall}, 32'd1);
    checkOutput("t2_hold_write2", {31'd0, memWrite}, 32'd1);
    stepClock();
    checkOutput("t2_hold_release", {31'd0, stall}, 32'd0);
    checkOutput("t2_hold_memread", {31'd0, memRead}, 32'd1);
    checkOutput("t2_hold_data", ldData, 32'h22);
    stepClock();
`endif
    drainAll("t2");
    checkOutput("t2_mem", memPeek(6'd8), 32'h22);

    // Fill all four entries under a held load, then overflow.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h40 + 32'(4 * i), 32'(i + 1), 1, 32'h80);
      checkOutput("t3_fill_stall", {31'd0, stall}, 32'd0);
      checkOutput("t3_fill_nowrite", {31'd0, memWrite}, 32'd0);
      pushExp(32'h40 + 32'(4 * i), 32'(i + 1));
      stepClock();
    end
    applyStimulus(0, 1, 32'h50, 32'h5, 1, 32'h80);
    checkOutput("t3_full_stall", {31'd0, stall}, 32'd1);
    checkOutput("t3_full_nowrite", {31'd0, memWrite}, 32'd0);
    checkOutput("t3_full_memread", {31'd0, memRead}, 32'd1);
    checkOutput("t3_full_busy", {31'd0, empty}, 32'd0);
    stepClock();
    applyStimulus(0, 1, 32'h50, 32'h5, 0, 0);
    checkOutput("t3_drop_stall", {31'd0, stall}, 32'd0);
    checkOutput("t3_drop_write", {31'd0, memWrite}, 32'd1);
    checkOutput("t3_drop_addr", memAddress, 32'h40);
    pushExp(32'h50, 32'h5);
    stepClock();
    applyStimulus(0, 1, 32'h54, 32'h6, 1, 32'h80);
    checkOutput("t3_still_full", {31'd0, stall}, 32'd1);
    stepClock();
    drainAll("t3");

    // Load to the neighbouring word must not hit the buffered store.
    applyStimulus(0, 1, 32'h20, 32'h77, 1, 32'h80);
    checkOutput("t4_stall_a", {31'd0, stall}, 32'd0);
    pushExp(32'h20, 32'h77);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 32'h24);
    checkOutput("t4_stall_b", {31'd0, stall}, 32'd0);
    checkOutput("t4_memread", {31'd0, memRead}, 32'd1);
    checkOutput("t4_addr", memAddress, 32'h24);
    checkOutput("t4_nowrite", {31'd0, memWrite}, 32'd0);
    checkOutput("t4_data", ldData, 32'hA000_0009);
    stepClock();
    drainAll("t4");

    // Reset in the middle discards three buffered stores.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h60 + 32'(4 * i), 32'hAA0 + 32'(i), 1, 32'h80);
      stepClock();
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t5_rst_write", {31'd0, memWrite}, 32'd0);
    checkOutput("t5_rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("t5_rst_stall", {31'd0, stall}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_after_empty", {31'd0, empty}, 32'd1);
    checkOutput("t5_after_write", {31'd0, memWrite}, 32'd0);
    stepClock();
    checkOutput("t5_after_write2", {31'd0, memWrite}, 32'd0);
    checkOutput("t5_mem_60", memPeek(6'd24), 32'hA000_0018);
    checkOutput("t5_mem_64", memPeek(6'd25), 32'hA000_0019);
    checkOutput("t5_mem_68", memPeek(6'd26), 32'hA000_001A);

    // Load of 0x30 behind an older store to 0x34 and a store to 0x30.
    applyStimulus(0, 1, 32'h34, 32'h6, 1, 32'h80);
    pushExp(32'h34, 32'h6);
    stepClock();
    applyStimulus(0, 1, 32'h30, 32'h5, 1, 32'h80);
    pushExp(32'h30, 32'h5);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 32'h30);
`ifdef STORE_BUF_FWD_EN
    checkOutput("t6_fwd_stall", {31'd0, stall}, 32'd0);
    checkOutput("t6_fwd_data", ldData, 32'h5);
    checkOutput("t6_fwd_nowrite", {31'd0, memWrite}, 32'd0);
    stepClock();
`else
    checkOutput("t6_hold_stall1", {31'd0, stall}, 32'd1);
    checkOutput("t6_hold_noread", {31'd0, memRead}, 32'd0);
    stepClock();
    checkOutput("t6_hold_stall2", {31'd0, stall}, 32'd1);
    stepClock();
    checkOutput("t6_release", {31'd0, stall}, 32'd0);
    checkOutput("t6_memread", {31'd0, memRead}, 32'd1);
    checkOutput("t6_data", ldData, 32'h5);
    stepClock();
`endif
    drainAll("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
